// File: rtl/bias_stream_tx.sv
// Bias streamer: interleaved bias RAM plus a start-triggered beat generator.
// One row per cycle is prefetched into a 2-entry buffer that drives the beat handshake.
module bias_stream_tx #(
    parameter int BIAS_W = 32,
    parameter int LANES  = 2,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic                      sclk,
    input  logic                      s_rst_n,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [BIAS_W-1:0]         wr_data,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [CNT_W-1:0]          num_bias,
    output logic                      busy,
    output logic                      done,
    output logic [LANES*BIAS_W-1:0]   bias_data,
    output logic                      bias_valid,
    output logic                      bias_last,
    input  logic                      ready
);
    localparam int LB   = $clog2(LANES);
    localparam int ROWS = DEPTH / LANES;
    localparam int RW   = (LB < ADDR_W) ? ADDR_W - LB : 1;
    localparam int LW   = $clog2(LANES + 1);
    localparam logic [CNT_W-1:0] LANES_C  = CNT_W'(LANES);
    localparam logic [RW-1:0]    LAST_ROW = RW'(ROWS - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state_reg, state_next;

    logic [RW-1:0]           row_ptr_reg, rd_row, wr_row;
    logic [CNT_W-1:0]        words_left_reg, rd_words, words_after;
    logic                    rd_en, rd_pend_reg, rd_last_reg;
    logic [LW-1:0]           rd_nlanes_reg;
    logic [LANES*BIAS_W-1:0] push_data;
    logic [LANES*BIAS_W-1:0] fifo_data_reg [2];
    logic [1:0]              fifo_last_reg;
    logic                    fifo_rd_ptr_reg, fifo_wr_ptr_reg;
    logic [1:0]              fifo_cnt_reg;
    logic                    done_reg;
    logic                    pop, room, accept_start, zero_start, final_pop;
    logic [2:0]              occ;

    assign wr_row       = RW'(wr_addr >> LB);
    assign accept_start = (state_reg == S_IDLE) && start && !done_reg && (num_bias != '0);
    assign zero_start   = (state_reg == S_IDLE) && start && !done_reg && (num_bias == '0);
    assign pop          = (fifo_cnt_reg != 2'd0) && ready;
    assign final_pop    = (state_reg == S_RUN) && pop && fifo_last_reg[fifo_rd_ptr_reg];
    // Buffered plus in-flight beats after this cycle's pop must leave space for a new read.
    assign occ          = 3'(fifo_cnt_reg) + 3'(rd_pend_reg) - 3'(pop);
    assign room         = (occ < 3'd2);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_bank
            logic [BIAS_W-1:0] mem [ROWS];
            logic [BIAS_W-1:0] q_reg;
            logic              bank_we;

            assign bank_we = wr_en && ((wr_addr % ADDR_W'(LANES)) == ADDR_W'(gi));

            always_ff @(posedge sclk) begin
                if (bank_we)
                    mem[wr_row] <= wr_data;
                if (rd_en)
                    q_reg <= mem[rd_row];
            end

            assign push_data[gi*BIAS_W +: BIAS_W] = (LW'(gi) < rd_nlanes_reg) ? q_reg : '0;
        end
    endgenerate

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept_start) state_next = S_RUN;
            S_RUN:  if (final_pop)    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_reg == S_RUN);
        done       = done_reg;
        bias_valid = (fifo_cnt_reg != 2'd0);
        bias_data  = fifo_data_reg[fifo_rd_ptr_reg];
        bias_last  = fifo_last_reg[fifo_rd_ptr_reg] && (fifo_cnt_reg != 2'd0);
    end

    // The first row is read in the start cycle itself so valid appears two cycles later.
    always_comb begin
        rd_en    = 1'b0;
        rd_row   = row_ptr_reg;
        rd_words = words_left_reg;
        if (accept_start) begin
            rd_en    = 1'b1;
            rd_row   = RW'(base_addr >> LB);
            rd_words = num_bias;
        end else if ((state_reg == S_RUN) && (words_left_reg != '0) && room) begin
            rd_en = 1'b1;
        end
        words_after = (rd_words > LANES_C) ? rd_words - LANES_C : '0;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            done_reg         <= 1'b0;
            row_ptr_reg      <= '0;
            words_left_reg   <= '0;
            rd_pend_reg      <= 1'b0;
            rd_last_reg      <= 1'b0;
            rd_nlanes_reg    <= '0;
            fifo_data_reg[0] <= '0;
            fifo_data_reg[1] <= '0;
            fifo_last_reg    <= '0;
            fifo_rd_ptr_reg  <= 1'b0;
            fifo_wr_ptr_reg  <= 1'b0;
            fifo_cnt_reg     <= '0;
        end else begin
            done_reg    <= zero_start || final_pop;
            rd_pend_reg <= rd_en;
            if (rd_en) begin
                row_ptr_reg    <= (rd_row == LAST_ROW) ? '0 : rd_row + RW'(1);
                words_left_reg <= words_after;
                rd_last_reg    <= (rd_words <= LANES_C);
                rd_nlanes_reg  <= (rd_words >= LANES_C) ? LW'(LANES) : rd_words[LW-1:0];
            end
            if (rd_pend_reg) begin
                fifo_data_reg[fifo_wr_ptr_reg] <= push_data;
                fifo_last_reg[fifo_wr_ptr_reg] <= rd_last_reg;
                fifo_wr_ptr_reg                <= ~fifo_wr_ptr_reg;
            end
            if (pop)
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            fifo_cnt_reg <= fifo_cnt_reg + 2'(rd_pend_reg) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_bias_stream_tx.sv
// Scoreboard bench for bias_stream_tx: directed sets push expected beats,
// a negedge monitor pops and compares on every accepted beat.
module tb_bias_stream_tx;
    localparam int BIAS_W = 32;
    localparam int LANES  = 2;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 5;
    localparam int DW     = LANES * BIAS_W;

    logic              sclk = 1'b0;
    logic              s_rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [BIAS_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  num_bias = '0;
    logic              busy, done, bias_valid, bias_last;
    logic [DW-1:0]     bias_data;
    logic              ready = 1'b0;

    bias_stream_tx #(
        .BIAS_W(BIAS_W), .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .base_addr(base_addr), .num_bias(num_bias),
        .busy(busy), .done(done),
        .bias_data(bias_data), .bias_valid(bias_valid), .bias_last(bias_last),
        .ready(ready)
    );

    always #5 sclk = ~sclk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          acc_cnt = 0;
    bit          rand_ready = 1'b0;
    bit          stall_prev = 1'b0;
    logic [DW-1:0] held_data;
    logic        held_last;
    logic [DW:0] exp_q [$];
    int          words [16] = '{129, 395, -1099, 473, 119, 698, 537, 818,
                                -108, 1009, 364, 225, -2467, -162, 368, -174};

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic wr_word(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic push_beat(input int hi, input int lo, input bit last);
        logic [BIAS_W-1:0] h, l;
        h = hi;
        l = lo;
        exp_q.push_back({last, h, l});
    endtask

    task automatic start_set(input int base, input int num);
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        num_bias  = CNT_W'(num);
        tick();
        start = 1'b0;
        check("latency_cycle1_valid", bias_valid, 0);
        tick();
        check("latency_cycle2_valid", bias_valid, 1);
    endtask

    task automatic wait_done(input string name);
        int d0;
        d0 = done_cnt;
        for (int n = 0; n < 300; n++) begin
            @(negedge sclk);
            if (done) break;
        end
        check({name, "_done_seen"}, done, 1);
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_valid_at_done"}, bias_valid, 0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        tick();
        tick();
        check({name, "_done_count"}, done_cnt, d0 + 1);
    endtask

    always @(posedge sclk) begin
        #2;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    end

    always @(negedge sclk) begin
        logic [DW:0] e;
        if (!s_rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (stall_prev) begin
                check("stall_valid", bias_valid, 1);
                check("stall_data", bias_data, held_data);
                check("stall_last", bias_last, held_last);
            end
            if (bias_valid && ready) begin
                acc_cnt++;
                $display("beat %0d: data=%h last=%0b", acc_cnt, bias_data, bias_last);
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", bias_data, e[DW-1:0]);
                    check("beat_last", bias_last, e[DW]);
                end
                stall_prev = 1'b0;
            end else if (bias_valid) begin
                stall_prev = 1'b1;
                held_data  = bias_data;
                held_last  = bias_last;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic push_full_set();
        push_beat(395, 129, 0);     push_beat(473, -1099, 0);
        push_beat(698, 119, 0);     push_beat(818, 537, 0);
        push_beat(1009, -108, 0);   push_beat(225, 364, 0);
        push_beat(-162, -2467, 0);  push_beat(-174, 368, 1);
    endtask

    initial begin
        int a0, d0, n;
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", bias_valid, 0);
        check("reset_last", bias_last, 0);
        check("reset_data", bias_data, 0);
        @(negedge sclk);
        s_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) wr_word(i, words[i]);

        // full set, always ready
        ready = 1'b1;
        push_full_set();
        start_set(0, 16);
        wait_done("full_ready");

        // full set, random backpressure
        rand_ready = 1'b1;
        push_full_set();
        start_set(0, 16);
        wait_done("full_random");
        rand_ready = 1'b0;
        ready = 1'b1;
        tick();

        // partial last beat
        push_beat(698, 119, 0);
        push_beat(818, 537, 0);
        push_beat(0, -108, 1);
        start_set(4, 5);
        wait_done("partial");

        // single word, base low bit ignored
        push_beat(0, -1099, 1);
        start_set(2, 1);
        wait_done("single");

        // zero count, then a start held into the done cycle must be ignored
        start     = 1'b1;
        base_addr = '0;
        num_bias  = '0;
        tick();
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_valid", bias_valid, 0);
        num_bias = CNT_W'(2);
        tick();
        start = 1'b0;
        check("start_in_done_busy", busy, 0);
        check("zero_done_clears", done, 0);
        tick();
        tick();
        check("start_in_done_valid", bias_valid, 0);

        // row pointer wrap
        push_beat(-174, 368, 0);
        push_beat(395, 129, 1);
        start_set(14, 4);
        wait_done("wrap");

        // stall at beat 3, then asynchronous reset mid-stream
        ready = 1'b1;
        push_full_set();
        a0 = acc_cnt;
        start_set(0, 16);
        n = 0;
        while ((acc_cnt - a0) < 3 && n < 50) begin
            tick();
            n++;
        end
        ready = 1'b0;
        check("stall_accepted_beats", acc_cnt - a0, 3);
        tick();
        tick();
        check("stall_busy", busy, 1);
        check("stall_held_valid", bias_valid, 1);
        d0 = done_cnt;
        #2;
        s_rst_n = 1'b0;
        #1;
        check("async_reset_valid", bias_valid, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_last", bias_last, 0);
        check("async_reset_done", done, 0);
        exp_q.delete();
        tick();
        @(negedge sclk);
        s_rst_n = 1'b1;
        tick();
        ready = 1'b1;
        tick();
        check("no_done_after_reset", done_cnt, d0);
        push_beat(395, 129, 1);
        start_set(0, 2);
        wait_done("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end
endmodule
